// File: rtl/ddr_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_burst_arbiter
//  Brief    : Round-robin N-channel burst arbiter in front of the single
//             rd/wr burst port of ddr_controller (ui_clk domain). Steers
//             beats to the owning channel and flags beat-count mismatches.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_burst_arbiter #(
   parameter int NUM_CH         = 4,
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int DDR_DATA_WIDTH = 128,
   parameter int LEN_WIDTH      = 10
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NUM_CH-1:0]                  ch_req_i,
   input  logic [NUM_CH-1:0]                  ch_we_i,
   input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]   ch_addr_i,
   input  logic [NUM_CH*LEN_WIDTH-1:0]        ch_len_i,
   input  logic [NUM_CH*DDR_DATA_WIDTH-1:0]   ch_wr_data_i,
   output logic [NUM_CH-1:0]                  ch_ack_o,
   output logic [NUM_CH-1:0]                  ch_done_o,
   output logic [NUM_CH-1:0]                  ch_rd_valid_o,
   output logic [NUM_CH-1:0]                  ch_wr_data_req_o,
   output logic                               rd_burst_req_o,
   output logic                               wr_burst_req_o,
   output logic [DDR_ADDR_WIDTH-1:0]          rd_burst_addr_o,
   output logic [DDR_ADDR_WIDTH-1:0]          wr_burst_addr_o,
   output logic [LEN_WIDTH-1:0]               rd_burst_len_o,
   output logic [LEN_WIDTH-1:0]               wr_burst_len_o,
   output logic [DDR_DATA_WIDTH-1:0]          wr_burst_data_o,
   input  logic                               rd_burst_data_valid_i,
   input  logic                               wr_burst_data_req_i,
   input  logic                               rd_burst_finish_i,
   input  logic                               wr_burst_finish_i,
   output logic                               busy_o,
   output logic [2:0]                         owner_o,
   output logic                               len_err_o
);

   // Channel indices are carried as 3 bits (up to 8 channels); per-channel
   // fields are unpacked into 8-entry tables so a 3-bit index never overruns.
   localparam int         CNT_W   = LEN_WIDTH + 1;
   localparam logic [3:0] NUM_CH4 = 4'(NUM_CH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]                state_q, state_d;
   logic [NUM_CH-1:0]         ack_q,   ack_d;
   logic [2:0]                owner_q, owner_d;
   logic [2:0]                ptr_q,   ptr_d;
   logic [DDR_ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic [LEN_WIDTH-1:0]      len_q,   len_d;
   logic [CNT_W-1:0]          cnt_q,   cnt_d;
   logic                      err_q,   err_d;

   logic [7:0]                req_p;
   logic [7:0]                we_p;
   logic [DDR_ADDR_WIDTH-1:0] addr_p [8];
   logic [LEN_WIDTH-1:0]      len_p  [8];
   logic [DDR_DATA_WIDTH-1:0] data_p [8];

   logic                      pick_vld;
   logic [2:0]                pick;
   logic [3:0]                rr_sum;
   logic                      beat;
   logic                      done_cyc;

   genvar g;

   // Unpack the flat per-channel buses; unused slots read as zero.
   generate
      for (g = 0; g < 8; g++) begin : g_unpack
         if (g < NUM_CH) begin : g_used
            assign req_p[g]  = ch_req_i[g];
            assign we_p[g]   = ch_we_i[g];
            assign addr_p[g] = ch_addr_i[g*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
            assign len_p[g]  = ch_len_i[g*LEN_WIDTH +: LEN_WIDTH];
            assign data_p[g] = ch_wr_data_i[g*DDR_DATA_WIDTH +: DDR_DATA_WIDTH];
         end else begin : g_unused
            assign req_p[g]  = 1'b0;
            assign we_p[g]   = 1'b0;
            assign addr_p[g] = '0;
            assign len_p[g]  = '0;
            assign data_p[g] = '0;
         end
      end
   endgenerate

   // Round-robin search: first requester at or after the pointer, wrapping.
   always_comb begin
      pick_vld = 1'b0;
      pick     = 3'd0;
      rr_sum   = 4'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         rr_sum = {1'b0, ptr_q} + 4'(i);
         if (rr_sum >= NUM_CH4) rr_sum = rr_sum - NUM_CH4;
         if (!pick_vld && req_p[rr_sum[2:0]]) begin
            pick_vld = 1'b1;
            pick     = rr_sum[2:0];
         end
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Grant, burst descriptor, pointer, beat counter and sticky error registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_q   <= '0;
         owner_q <= 3'd0;
         ptr_q   <= 3'd0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         ack_q   <= ack_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign beat = ((state_q == ST_RD) && rd_burst_data_valid_i) ||
                 ((state_q == ST_WR) && wr_burst_data_req_i);

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      ack_d   = '0;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_burst_finish_i || wr_burst_finish_i) err_d = 1'b1;
            if (pick_vld) begin
               for (int i = 0; i < NUM_CH; i++) ack_d[i] = (pick == 3'(i));
               owner_d = pick;
               addr_d  = addr_p[pick];
               len_d   = len_p[pick];
               cnt_d   = '0;
               ptr_d   = ({1'b0, pick} + 4'd1 >= NUM_CH4) ? 3'd0 : pick + 3'd1;
               if (len_p[pick] == '0) state_d = ST_DONE;
               else if (we_p[pick])   state_d = ST_WR;
               else                   state_d = ST_RD;
            end
         end
         ST_RD: begin
            if (beat) cnt_d = cnt_q + 1'b1;
            if (wr_burst_finish_i) err_d = 1'b1;
            if (rd_burst_finish_i) begin
               state_d = ST_DONE;
               if (cnt_d != {1'b0, len_q}) err_d = 1'b1;
            end
         end
         ST_WR: begin
            if (beat) cnt_d = cnt_q + 1'b1;
            if (rd_burst_finish_i) err_d = 1'b1;
            if (wr_burst_finish_i) begin
               state_d = ST_DONE;
               if (cnt_d != {1'b0, len_q}) err_d = 1'b1;
            end
         end
         default: begin
            if (rd_burst_finish_i || wr_burst_finish_i) err_d = 1'b1;
            // A zero-length grant enters DONE with its ack still showing;
            // hold one extra cycle so the done pulse follows the ack.
            if (ack_q == '0) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      rd_burst_req_o = (state_q == ST_RD);
      wr_burst_req_o = (state_q == ST_WR);
      busy_o         = (state_q != ST_IDLE);
      done_cyc       = (state_q == ST_DONE) && (ack_q == '0);
   end

   // Per-channel steering of beat strobes and the completion pulse.
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_steer
         assign ch_rd_valid_o[g]    = rd_burst_req_o && (owner_q == 3'(g)) && rd_burst_data_valid_i;
         assign ch_wr_data_req_o[g] = wr_burst_req_o && (owner_q == 3'(g)) && wr_burst_data_req_i;
         assign ch_done_o[g]        = done_cyc && (owner_q == 3'(g));
      end
   endgenerate

   assign ch_ack_o        = ack_q;
   assign owner_o         = owner_q;
   assign len_err_o       = err_q;
   assign rd_burst_addr_o = addr_q;
   assign wr_burst_addr_o = addr_q;
   assign rd_burst_len_o  = len_q;
   assign wr_burst_len_o  = len_q;
   assign wr_burst_data_o = data_p[owner_q];

endmodule
`default_nettype wire
